// File: rtl/mole_game_ctrl.sv
// Whack-a-mole game engine: random hole selection, mole window timing, hit judging and scoring.
// Optional MOLE_SPEEDUP_EN shortens the mole window after every correct hit, down to MIN_MS.
module mole_game_ctrl #(
    parameter int TICK_DIV   = 100000,
    parameter int MOLE_MS    = 1000,
    parameter int FB_MS      = 250,
    parameter int SPEEDUP_MS = 50,
    parameter int MIN_MS     = 200
) (
    input  logic       master_clk,
    input  logic       rst_n,
    input  logic [7:0] hit,
    output logic [2:0] mole_position,
    output logic       mole_visible,
    output logic       guess_correct,
    output logic       guess_wrong,
    output logic [7:0] score,
    output logic [7:0] misses
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TW = 16;

    typedef enum logic [1:0] {
        SPAWN  = 2'd0,
        SHOW   = 2'd1,
        FB_OK  = 2'd2,
        FB_BAD = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [7:0]      r_lfsr;
    logic [PW-1:0]   r_presc;
    logic [TW-1:0]   r_timer;
    logic [7:0]      r_hit_prev;
    logic [2:0]      r_pos;
    logic            r_visible;
    logic            r_correct;
    logic            r_wrong;
    logic [7:0]      r_score;
    logic [7:0]      r_misses;

    logic            w_tick;
    logic [7:0]      w_rise;
    logic [7:0]      w_sel;
    logic            w_wrong_edge;
    logic            w_right_edge;
    logic [2:0]      w_cand;
    logic [2:0]      w_pos_nxt;
    logic [7:0]      w_score_nxt;
    logic [7:0]      w_misses_nxt;
    logic            w_hit_ok;
    logic [TW-1:0]   w_window;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    assign w_tick       = (r_presc == PW'(TICK_DIV - 1));
    assign w_rise       = hit & ~r_hit_prev;
    assign w_sel        = 8'd1 << r_pos;
    assign w_wrong_edge = |(w_rise & ~w_sel);
    assign w_right_edge = |(w_rise & w_sel);
    assign w_cand       = r_lfsr[2:0];

`ifdef MOLE_SPEEDUP_EN
    logic [TW-1:0] r_window;

    // Window shrinks on each correct hit, clamped at the floor.
    always_ff @(posedge master_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_window <= TW'(MOLE_MS);
        end else if (w_hit_ok) begin
            r_window <= (r_window >= TW'(MIN_MS + SPEEDUP_MS)) ? r_window - TW'(SPEEDUP_MS) : TW'(MIN_MS);
        end else begin
            r_window <= r_window;
        end
    end

    assign w_window = r_window;
`else
    assign w_window = TW'(MOLE_MS);
`endif

    // Next-state and next-score logic; wrong edges outrank the correct edge, any edge outranks timeout.
    always_comb begin
        w_state_nxt  = r_state;
        w_pos_nxt    = r_pos;
        w_score_nxt  = r_score;
        w_misses_nxt = r_misses;
        w_hit_ok     = 1'b0;
        case (r_state)
            SPAWN: begin
                w_pos_nxt   = (w_cand == r_pos) ? w_cand + 3'd1 : w_cand;
                w_state_nxt = SHOW;
            end
            SHOW: begin
                if (w_wrong_edge) begin
                    w_misses_nxt = sat_inc(r_misses);
                    w_state_nxt  = FB_BAD;
                end else if (w_right_edge) begin
                    w_score_nxt  = sat_inc(r_score);
                    w_hit_ok     = 1'b1;
                    w_state_nxt  = FB_OK;
                end else if (w_tick && (r_timer == w_window - TW'(1))) begin
                    w_misses_nxt = sat_inc(r_misses);
                    w_state_nxt  = FB_BAD;
                end else begin
                    w_state_nxt  = SHOW;
                end
            end
            FB_OK, FB_BAD: begin
                if (w_tick && (r_timer == TW'(FB_MS - 1))) begin
                    w_state_nxt = SPAWN;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            default: begin
                w_state_nxt = SPAWN;
            end
        endcase
    end

    // State, free-running prescaler/LFSR, per-state tick timer and edge-detect history.
    always_ff @(posedge master_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= SPAWN;
            r_lfsr     <= 8'hA5;
            r_presc    <= '0;
            r_timer    <= '0;
            r_hit_prev <= 8'hFF;
        end else begin
            r_state    <= w_state_nxt;
            r_lfsr     <= lfsr_step(r_lfsr);
            r_presc    <= w_tick ? '0 : r_presc + PW'(1);
            r_hit_prev <= hit;
            if (w_state_nxt != r_state) begin
                r_timer <= '0;
            end else if (w_tick) begin
                r_timer <= r_timer + TW'(1);
            end else begin
                r_timer <= r_timer;
            end
        end
    end

    // Registered outputs follow the state being entered, so feedback appears the cycle after the edge.
    always_ff @(posedge master_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pos     <= 3'd0;
            r_visible <= 1'b0;
            r_correct <= 1'b0;
            r_wrong   <= 1'b0;
            r_score   <= 8'd0;
            r_misses  <= 8'd0;
        end else begin
            r_pos     <= w_pos_nxt;
            r_visible <= (w_state_nxt == SHOW);
            r_correct <= (w_state_nxt == FB_OK);
            r_wrong   <= (w_state_nxt == FB_BAD);
            r_score   <= w_score_nxt;
            r_misses  <= w_misses_nxt;
        end
    end

    assign mole_position = r_pos;
    assign mole_visible  = r_visible;
    assign guess_correct = r_correct;
    assign guess_wrong   = r_wrong;
    assign score         = r_score;
    assign misses        = r_misses;

endmodule
